snn_tick_scheduler: RTL

SNN_TICK_SCHEDULER -- requirements
Module: snn_tick_scheduler

---
 rtl/snn_pkg.sv | 39 +++
 rtl/snn_neuron_update.sv | 26 ++
 rtl/snn_tick_scheduler.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared defaults, FSM state encoding and saturating arithmetic for the SNN tick scheduler.
package snn_pkg;

    localparam int unsigned SNN_NUM_NEURONS = 16;
    localparam int unsigned SNN_NUM_INPUTS  = 16;
    localparam int unsigned SNN_WEIGHT_W    = 8;
    localparam int unsigned SNN_POT_W       = 16;
    localparam int unsigned SAT_W           = 48;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ACCUM  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_UPDATE = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    // Wide signed add clamped to the signed range of a w-bit value.
    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int unsigned             w
    );
        logic signed [SAT_W-1:0] sum;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sum = a + b;
        hi  = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
        lo  = ~hi;
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/snn_neuron_update.sv
// Combinational membrane update: pot + acc - leak with saturation, threshold fire, floor at zero.
module snn_neuron_update
    import snn_pkg::*;
#(
    parameter int unsigned POT_W = SNN_POT_W,
    parameter int unsigned ACC_W = SNN_POT_W + $clog2(SNN_NUM_INPUTS) + 1
) (
    input  logic signed [POT_W-1:0] pot_i,
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic signed [POT_W-1:0] leak_i,
    input  logic signed [POT_W-1:0] threshold_i,
    output logic                    fire_o,
    output logic signed [POT_W-1:0] pot_next_o
);

    logic signed [SAT_W-1:0] v_wide;
    logic signed [POT_W-1:0] v;

    always_comb begin
        v_wide     = sat_add(SAT_W'(pot_i) + SAT_W'(acc_i), -SAT_W'(leak_i), POT_W);
        v          = POT_W'(v_wide);
        fire_o     = (v >= threshold_i);
        pot_next_o = (fire_o || v[POT_W-1]) ? '0 : v;
    end

endmodule

// File: rtl/snn_tick_scheduler.sv
// Per-tick SNN sequencer: accumulates spike-gated weights per neuron, updates potentials, fires.
// Optional per-tick leak input is enabled by defining SNN_LEAK_EN.
module snn_tick_scheduler
    import snn_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = SNN_NUM_NEURONS,
    parameter int unsigned NUM_INPUTS  = SNN_NUM_INPUTS,
    parameter int unsigned WEIGHT_W    = SNN_WEIGHT_W,
    parameter int unsigned POT_W       = SNN_POT_W,
    localparam int unsigned AW         = $clog2(NUM_NEURONS * NUM_INPUTS)
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_n_i,
    input  logic                    start_i,
    input  logic [NUM_INPUTS-1:0]   spikes_in_i,
    input  logic signed [POT_W-1:0] threshold_i,
`ifdef SNN_LEAK_EN
    input  logic signed [POT_W-1:0] leak_i,
`endif
    output logic                    busy_o,
    output logic                    done_o,
    output logic [NUM_NEURONS-1:0]  spikes_out_o,
    input  logic                    host_req_i,
    input  logic                    host_we_i,
    input  logic [AW-1:0]           host_addr_i,
    input  logic [WEIGHT_W-1:0]     host_wdata_i,
    output logic                    host_gnt_o,
    output logic [WEIGHT_W-1:0]     host_rdata_o,
    output logic                    mem_en_o,
    output logic                    mem_we_o,
    output logic [AW-1:0]           mem_addr_o,
    output logic [WEIGHT_W-1:0]     mem_wdata_o,
    input  logic [WEIGHT_W-1:0]     mem_rdata_i
);

    localparam int unsigned NI_W  = $clog2(NUM_INPUTS);
    localparam int unsigned NN_W  = $clog2(NUM_NEURONS);
    localparam int unsigned ACC_W = POT_W + NI_W + 1;

    state_e                  state_q, state_d;
    logic [NN_W-1:0]         n_q, n_d;
    logic [NI_W-1:0]         i_q, i_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    rd_pend_q, rd_pend_d;
    logic [NUM_INPUTS-1:0]   spk_in_q, spk_in_d;
    logic [NUM_NEURONS-1:0]  spk_q, spk_d;
    logic signed [POT_W-1:0] pot_q [NUM_NEURONS];
    logic signed [POT_W-1:0] pot_d [NUM_NEURONS];
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [NUM_NEURONS-1:0]  spikes_out_q, spikes_out_d;

    logic signed [POT_W-1:0] leak_w;
    logic                    upd_fire;
    logic signed [POT_W-1:0] upd_pot;

`ifdef SNN_LEAK_EN
    assign leak_w = leak_i;
`else
    assign leak_w = '0;
`endif

    snn_neuron_update #(
        .POT_W (POT_W),
        .ACC_W (ACC_W)
    ) u_neuron_update (
        .pot_i       (pot_q[n_q]),
        .acc_i       (acc_q),
        .leak_i      (leak_w),
        .threshold_i (threshold_i),
        .fire_o      (upd_fire),
        .pot_next_o  (upd_pot)
    );

    // Weight RAM returns data one cycle after the request, so host read data is a pass-through.
    assign host_rdata_o = mem_rdata_i;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign spikes_out_o = spikes_out_q;

    // Next-state and memory-port arbitration; host only owns the port while idle.
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        i_d          = i_q;
        acc_d        = acc_q;
        rd_pend_d    = 1'b0;
        spk_in_d     = spk_in_q;
        spk_d        = spk_q;
        pot_d        = pot_q;
        spikes_out_d = spikes_out_q;
        host_gnt_o   = 1'b0;
        mem_en_o     = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;

        if (rd_pend_q) begin
            acc_d = acc_q + ACC_W'(signed'(mem_rdata_i));
        end

        case (state_q)
            ST_IDLE: begin
                host_gnt_o  = host_req_i & wb_rst_n_i;
                mem_en_o    = host_req_i & wb_rst_n_i;
                mem_we_o    = host_we_i;
                mem_addr_o  = host_addr_i;
                mem_wdata_o = host_wdata_i;
                if (start_i) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                spk_in_d = spikes_in_i;
                n_d      = '0;
                i_d      = '0;
                acc_d    = '0;
                state_d  = ST_ACCUM;
            end
            ST_ACCUM: begin
                mem_en_o   = spk_in_q[i_q];
                mem_addr_o = AW'(n_q) * AW'(NUM_INPUTS) + AW'(i_q);
                rd_pend_d  = spk_in_q[i_q];
                if (i_q == NI_W'(NUM_INPUTS - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    i_d = i_q + NI_W'(1);
                end
            end
            ST_DRAIN: begin
                state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                pot_d[n_q] = upd_pot;
                spk_d[n_q] = upd_fire;
                acc_d      = '0;
                i_d        = '0;
                if (n_q == NN_W'(NUM_NEURONS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    n_d     = n_q + NN_W'(1);
                    state_d = ST_ACCUM;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        if (state_d == ST_DONE) begin
            spikes_out_d = spk_d;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q      <= ST_IDLE;
            n_q          <= '0;
            i_q          <= '0;
            acc_q        <= '0;
            rd_pend_q    <= 1'b0;
            spk_in_q     <= '0;
            spk_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            spikes_out_q <= '0;
            for (int k = 0; k < int'(NUM_NEURONS); k++) begin
                pot_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            i_q          <= i_d;
            acc_q        <= acc_d;
            rd_pend_q    <= rd_pend_d;
            spk_in_q     <= spk_in_d;
            spk_q        <= spk_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            spikes_out_q <= spikes_out_d;
            pot_q        <= pot_d;
        end
    end

endmodule
